// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Purpose  : State codes, opcodes, mux encodings and control bundle shared by
//            the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Purpose  : Controller <-> datapath bundle: opcode/ready in, enables out.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if
  import multicycle_ctrl_pkg::*;
();
  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               pc_write, pc_write_cond, ir_write, mdr_write;
  logic               ab_write, aluout_write, reg_write;
  logic               mem_read, mem_write;
  logic               iord, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0]         alu_src_b, alu_op, pc_source;
  logic               illegal;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, mdr_write, ab_write,
           aluout_write, reg_write, mem_read, mem_write, iord, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, mdr_write, ab_write,
           aluout_write, reg_write, mem_read, mem_write, iord, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_decode
// Purpose  : Combinational map from state and mem_ready to control outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  wire logic   reset,
  input  state_t      state,
  input  wire logic   mem_ready,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    // Reset overrides the FETCH decode so no strobe leaks out while held.
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b    = SRCB_BRIMM;
          ctrl.ab_write     = 1'b1;
          ctrl.aluout_write = 1'b1;
        end
        S_MEMADR, S_ADDIEX: begin
          ctrl.alu_src_a    = 1'b1;
          ctrl.alu_src_b    = SRCB_IMM;
          ctrl.alu_op       = ALU_ADD;
          ctrl.aluout_write = 1'b1;
        end
        S_MEMRD: begin
          ctrl.mem_read  = 1'b1;
          ctrl.iord      = 1'b1;
          ctrl.mdr_write = mem_ready;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a    = 1'b1;
          ctrl.alu_src_b    = SRCB_B;
          ctrl.alu_op       = ALU_FUNCT;
          ctrl.aluout_write = 1'b1;
        end
        S_ALUWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_ADDIWB: ctrl.reg_write = 1'b1;
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ILLEGAL: ctrl.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle MIPS main control FSM (state register + next state).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          reset,
  multicycle_ctrl_if.master  bus
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      // IR holds the opcode, so it can be re-examined to split lw from sw.
      S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .reset     (reset),
    .state     (r_state),
    .mem_ready (bus.mem_ready),
    .ctrl      (w_ctrl)
  );

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mdr_write     = w_ctrl.mdr_write;
  assign bus.ab_write      = w_ctrl.ab_write;
  assign bus.aluout_write  = w_ctrl.aluout_write;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.iord          = w_ctrl.iord;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.illegal       = w_ctrl.illegal;
  assign bus.state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [19:0] RST_MASK = 20'hFF800;

  typedef struct {
    logic [3:0]  st;
    logic [19:0] w;
    bit          rst;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Expected control word per state, written out from the state table.
  function automatic logic [19:0] exp_word(input int st, input bit rdy);
    logic pcw, pcwc, irw, mdrw, abw, aow, rw, mr, mw, iord, m2r, rdst, asa, ill;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, irw, mdrw, abw, aow, rw, mr, mw, iord, m2r, rdst, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      1:  begin asb = 2'b11; abw = 1; aow = 1; end
      2:  begin asa = 1; asb = 2'b10; aow = 1; end
      3:  begin mr = 1; iord = 1; mdrw = rdy; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; aow = 1; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; aow = 1; end
      10: rw = 1;
      11: begin pcw = 1; psrc = 2'b10; end
      12: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, irw, mdrw, abw, aow, rw, mr, mw, iord, m2r, rdst, asa,
            asb, aop, psrc, ill};
  endfunction

  function automatic logic [19:0] act_word();
    return {bus_if.pc_write, bus_if.pc_write_cond, bus_if.ir_write,
            bus_if.mdr_write, bus_if.ab_write, bus_if.aluout_write,
            bus_if.reg_write, bus_if.mem_read, bus_if.mem_write, bus_if.iord,
            bus_if.mem_to_reg, bus_if.reg_dst, bus_if.alu_src_a,
            bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_source, bus_if.illegal};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares at negedge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) begin
        check("rst_state", {16'b0, bus_if.state_o}, 20'd0);
        check("rst_enables", act_word() & RST_MASK, 20'd0);
      end else begin
        check($sformatf("state@s%0d", e.st), {16'b0, bus_if.state_o}, {16'b0, e.st});
        check($sformatf("ctrl@s%0d", e.st), act_word(), e.w);
      end
    end
  end

  task automatic step(input logic [5:0] opc, input bit rdy, input bit rst, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    bus_if.opcode    = opc;
    bus_if.mem_ready = rdy;
    reset            = rst;
    e.rst = rst;
    e.st  = st[3:0];
    e.w   = exp_word(st, rdy);
    q.push_back(e);
  endtask

  initial begin
    bus_if.opcode    = 6'h00;
    bus_if.mem_ready = 1'b1;

    // Reset for 3 cycles, then R-type
    repeat (3) step(6'h00, 1, 1, 0);
    step(6'h00, 1, 0, 0);
    step(6'h00, 1, 0, 1);
    step(6'h00, 1, 0, 6);
    step(6'h00, 1, 0, 7);

    // lw with two MEMRD stall cycles
    step(6'h23, 1, 0, 0);
    step(6'h23, 1, 0, 1);
    step(6'h23, 1, 0, 2);
    step(6'h23, 0, 0, 3);
    step(6'h23, 0, 0, 3);
    step(6'h23, 1, 0, 3);
    step(6'h23, 1, 0, 4);

    // sw with one FETCH stall cycle
    step(6'h2B, 0, 0, 0);
    step(6'h2B, 1, 0, 0);
    step(6'h2B, 1, 0, 1);
    step(6'h2B, 1, 0, 2);
    step(6'h2B, 1, 0, 5);

    // beq then j
    step(6'h04, 1, 0, 0);
    step(6'h04, 1, 0, 1);
    step(6'h04, 1, 0, 8);
    step(6'h02, 1, 0, 0);
    step(6'h02, 1, 0, 1);
    step(6'h02, 1, 0, 11);

    // addi with mem_ready low where it must be ignored
    step(6'h08, 1, 0, 0);
    step(6'h08, 0, 0, 1);
    step(6'h08, 0, 0, 9);
    step(6'h08, 0, 0, 10);

    // illegal opcode
    step(6'h3F, 1, 0, 0);
    step(6'h3F, 1, 0, 1);
    step(6'h3F, 1, 0, 12);

    // sw stalled in MEMWR
    step(6'h2B, 1, 0, 0);
    step(6'h2B, 1, 0, 1);
    step(6'h2B, 1, 0, 2);
    step(6'h2B, 0, 0, 5);
    step(6'h2B, 1, 0, 5);

    // lw interrupted by async reset in MEMWB
    step(6'h23, 1, 0, 0);
    step(6'h23, 1, 0, 1);
    step(6'h23, 1, 0, 2);
    step(6'h23, 1, 0, 3);
    @(posedge clk);
    #1;
    check("memwb_state", {16'b0, bus_if.state_o}, 20'd4);
    check("memwb_reg_write", {19'b0, bus_if.reg_write}, 20'd1);
    reset = 1'b1;
    #1;
    check("async_rst_state", {16'b0, bus_if.state_o}, 20'd0);
    check("async_rst_reg_write", {19'b0, bus_if.reg_write}, 20'd0);
    check("async_rst_enables", act_word() & RST_MASK, 20'd0);
    step(6'h23, 1, 1, 0);
    step(6'h00, 1, 0, 0);
    step(6'h00, 1, 0, 1);
    step(6'h00, 1, 0, 6);
    step(6'h00, 1, 0, 7);
    step(6'h00, 1, 0, 0);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
